// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store.
// Data requests win, but a streak limit lets a waiting fetch through.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  // Arbitration (grants are combinational in IDLE) and next-state logic.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req_i && (!if_req_i || (streak_q < STREAK_MAX))) begin
          d_gnt_o     = 1'b1;
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_be_d    = d_be_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          // Streak only grows while fetch is actually being held off.
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (if_req_i) begin
          if_gnt_o    = 1'b1;
          state_d     = BUSY_I;
          streak_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready_i) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (mem_ready_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
          d_rvalid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        mem_be_d  = '0;
      end
    endcase
  end

  // Reset clears mem_req at once, so an aborted access never completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, wait states, streak
// fairness, reset abort and back-to-back routing.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_be_i      (d_be),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (3) step();
  endtask

  bit exp_is_d [10];
  int n_gnt;
  int cyc;

  initial begin
    exp_is_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset values
    repeat (2) step();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_gnts", 32'({if_gnt, d_gnt}), 0);
    check("rst_rvalids", 32'({if_rvalid, d_rvalid}), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    step();
    rst_n = 1'b1;

    // Single fetch
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    check("f_if_gnt", 32'(if_gnt), 1);
    check("f_d_gnt", 32'(d_gnt), 0);
    check("f_c0_mem_req", 32'(mem_req), 0);
    step();
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("f_c1_mem_req", 32'(mem_req), 1);
    check("f_c1_mem_addr", mem_addr, 32'h100);
    check("f_c1_mem_be", 32'(mem_be), 32'hF);
    check("f_c1_mem_we", 32'(mem_we), 0);
    check("f_c1_mem_wdata", mem_wdata, 0);
    check("f_c1_if_gnt", 32'(if_gnt), 0);
    step();
    @(negedge clk);
    check("f_c2_if_rvalid", 32'(if_rvalid), 1);
    check("f_c2_if_rdata", if_rdata, 32'h0050_0093);
    check("f_c2_d_rvalid", 32'(d_rvalid), 0);
    check("f_c2_mem_req", 32'(mem_req), 0);
    check("f_c2_mem_be", 32'(mem_be), 0);
    check("f_c2_mem_addr_hold", mem_addr, 32'h100);
    step();
    @(negedge clk);
    check("f_c3_if_rvalid", 32'(if_rvalid), 0);

    // Store with three wait cycles
    step();
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_DEAD;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_be = 4'h3; d_wdata = 32'hBEEF;
    @(negedge clk);
    check("s_d_gnt", 32'(d_gnt), 1);
    step();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      if (k == 3) mem_ready = 1'b1;
      @(negedge clk);
      check($sformatf("s_w%0d_mem_req", k), 32'(mem_req), 1);
      check($sformatf("s_w%0d_mem_addr", k), mem_addr, 32'h2004);
      check($sformatf("s_w%0d_mem_be", k), 32'(mem_be), 32'h3);
      check($sformatf("s_w%0d_mem_we", k), 32'(mem_we), 1);
      check($sformatf("s_w%0d_mem_wdata", k), mem_wdata, 32'hBEEF);
      check($sformatf("s_w%0d_d_rvalid", k), 32'(d_rvalid), 0);
    end
    step();
    @(negedge clk);
    check("s_d_rvalid", 32'(d_rvalid), 1);
    check("s_d_rdata_kept", d_rdata, 0);
    check("s_mem_req_low", 32'(mem_req), 0);
    check("s_mem_we_low", 32'(mem_we), 0);
    step();
    @(negedge clk);
    check("s_d_rvalid_pulse", 32'(d_rvalid), 0);

    // Simultaneous requests: streak limit lets fetch in every fifth grant
    step();
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    n_gnt = 0; cyc = 0;
    while (n_gnt < 10 && cyc < 60) begin
      @(negedge clk);
      check("sim_gnt_onehot", 32'(if_gnt & d_gnt), 0);
      check("sim_rvalid_excl", 32'(if_rvalid & d_rvalid), 0);
      if (if_gnt || d_gnt) begin
        check($sformatf("sim_grant%0d_is_d", n_gnt), 32'(d_gnt), 32'(exp_is_d[n_gnt]));
        n_gnt++;
      end
      step();
      cyc++;
    end
    check("sim_grant_count", 32'(n_gnt), 10);
    drain();

    // Fetch idle: data always wins and streak stays cleared
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; if_req = 1'b0;
    n_gnt = 0; cyc = 0;
    while (n_gnt < 4 && cyc < 30) begin
      @(negedge clk);
      check("idle_if_gnt", 32'(if_gnt), 0);
      if (d_gnt) begin
        check($sformatf("idle_streak%0d", n_gnt), 32'(dut.streak_q), 0);
        n_gnt++;
      end
      step();
      cyc++;
    end
    check("idle_grant_count", 32'(n_gnt), 4);
    drain();

    // Reset in the middle of a waited load
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    @(negedge clk);
    check("r_d_gnt", 32'(d_gnt), 1);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("r_mem_req_busy", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_mem_req_async", 32'(mem_req), 0);
    check("r_mem_be_async", 32'(mem_be), 0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("r_no_rvalid%0d", k), 32'(d_rvalid), 0);
      check($sformatf("r_no_mem_req%0d", k), 32'(mem_req), 0);
      step();
    end
    check("r_d_rdata_cleared", d_rdata, 0);
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    @(negedge clk);
    check("r_first_d_gnt", 32'(d_gnt), 1);
    check("r_first_if_gnt", 32'(if_gnt), 0);
    drain();

    // Back-to-back load then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("b_d_gnt", 32'(d_gnt), 1);
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    check("b_c1_mem_req", 32'(mem_req), 1);
    check("b_c1_mem_addr", mem_addr, 32'h3000);
    check("b_c1_if_gnt", 32'(if_gnt), 0);
    step();
    mem_rdata = 32'h3333_4444;
    @(negedge clk);
    check("b_c2_d_rvalid", 32'(d_rvalid), 1);
    check("b_c2_d_rdata", d_rdata, 32'h1111_2222);
    check("b_c2_if_gnt", 32'(if_gnt), 1);
    check("b_c2_if_rvalid", 32'(if_rvalid), 0);
    step();
    if_req = 1'b0;
    @(negedge clk);
    check("b_c3_mem_req", 32'(mem_req), 1);
    check("b_c3_mem_addr", mem_addr, 32'h104);
    check("b_c3_d_rvalid", 32'(d_rvalid), 0);
    step();
    @(negedge clk);
    check("b_c4_if_rvalid", 32'(if_rvalid), 1);
    check("b_c4_if_rdata", if_rdata, 32'h3333_4444);
    check("b_c4_d_rdata_kept", d_rdata, 32'h1111_2222);
    check("b_c4_d_rvalid", 32'(d_rvalid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
